// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry skid-free slot with operand resolution and divide guard.
// Define FWD_BYPASS_EN to forward MEM/WB results; otherwise matching sources stall decode.
package rv32i_pkg;
    parameter int XLEN = 32;
endpackage

module id_ex_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [3:0]      in_alu_op,
    input  logic            in_use_pc,
    input  logic            in_use_imm,
    input  logic            in_reg_write,
    input  logic            mem_fwd_valid,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] src_a,
    output logic [XLEN-1:0] src_b,
    output logic [3:0]      alu_instr,
    output logic [4:0]      out_rd_addr,
    output logic            out_reg_write,
    output logic [XLEN-1:0] out_pc,
    output logic            out_div_zero
);

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] src_a_q, src_a_d;
    logic [XLEN-1:0] src_b_q, src_b_d;
    logic [3:0]      alu_instr_q, alu_instr_d;
    logic [4:0]      out_rd_addr_q, out_rd_addr_d;
    logic            out_reg_write_q, out_reg_write_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_div_zero_q, out_div_zero_d;

    logic [XLEN-1:0] rs1_res, rs2_res;
    logic            hazard;
    logic            capture;

`ifdef FWD_BYPASS_EN
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] regdata);
        if (addr == 5'd0)                              return regdata;
        else if (mem_fwd_valid && mem_fwd_rd == addr)  return mem_fwd_data;
        else if (wb_fwd_valid && wb_fwd_rd == addr)    return wb_fwd_data;
        else                                           return regdata;
    endfunction

    assign hazard = 1'b0;
`else
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] regdata);
        logic [4:0] unused_addr;
        unused_addr = addr;
        return regdata;
    endfunction

    function automatic logic src_pending(input logic [4:0] addr);
        return (addr != 5'd0) &&
               ((mem_fwd_valid && mem_fwd_rd == addr) || (wb_fwd_valid && wb_fwd_rd == addr));
    endfunction

    // Without a bypass path the only safe option is to hold decode until the producer retires.
    assign hazard = (!in_use_pc && src_pending(in_rs1_addr)) ||
                    (!in_use_imm && src_pending(in_rs2_addr));

    logic unused_fwd_data;
    assign unused_fwd_data = ^{mem_fwd_data, wb_fwd_data};
`endif

    // valid/ready: a beat transfers on a rising edge where valid && ready; flush overrides both sides.
    always_comb begin
        rs1_res  = fwd(in_rs1_addr, in_rs1_data);
        rs2_res  = fwd(in_rs2_addr, in_rs2_data);
        in_ready = flush || ((!out_valid_q || out_ready) && !hazard);
        capture  = in_valid && in_ready && !flush;

        out_valid_d     = out_valid_q;
        src_a_d         = src_a_q;
        src_b_d         = src_b_q;
        alu_instr_d     = alu_instr_q;
        out_rd_addr_d   = out_rd_addr_q;
        out_reg_write_d = out_reg_write_q;
        out_pc_d        = out_pc_q;
        out_div_zero_d  = out_div_zero_q;

        if (flush)
            out_valid_d = 1'b0;
        else if (capture)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;

        if (capture) begin
            src_a_d         = in_use_pc  ? in_pc  : rs1_res;
            src_b_d         = in_use_imm ? in_imm : rs2_res;
            alu_instr_d     = in_alu_op;
            out_rd_addr_d   = in_rd_addr;
            out_reg_write_d = in_reg_write && (in_rd_addr != 5'd0);
            out_pc_d        = in_pc;
            out_div_zero_d  = (in_alu_op == 4'b1110 || in_alu_op == 4'b1111) &&
                              ((in_use_imm ? in_imm : rs2_res) == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            src_a_q         <= '0;
            src_b_q         <= '0;
            alu_instr_q     <= '0;
            out_rd_addr_q   <= '0;
            out_reg_write_q <= 1'b0;
            out_pc_q        <= '0;
            out_div_zero_q  <= 1'b0;
        end else begin
            out_valid_q     <= out_valid_d;
            src_a_q         <= src_a_d;
            src_b_q         <= src_b_d;
            alu_instr_q     <= alu_instr_d;
            out_rd_addr_q   <= out_rd_addr_d;
            out_reg_write_q <= out_reg_write_d;
            out_pc_q        <= out_pc_d;
            out_div_zero_q  <= out_div_zero_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign src_a         = src_a_q;
    assign src_b         = src_b_q;
    assign alu_instr     = alu_instr_q;
    assign out_rd_addr   = out_rd_addr_q;
    assign out_reg_write = out_reg_write_q;
    assign out_pc        = out_pc_q;
    assign out_div_zero  = out_div_zero_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL provide clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide in_valid/in_ready, input/output, 1 each, decode-side handshake.
REQ-004 SHALL provide in_pc, in_rs1_data, in_rs2_data, in_imm, inputs, XLEN (rv32i_pkg), decoded operands.
REQ-005 SHALL provide in_rs1_addr, in_rs2_addr, in_rd_addr, inputs, 5 each, register indices.
REQ-006 SHALL provide in_alu_op, input, 4, ALU opcode (0000 ADD ... 1111 MOD); in_use_pc, in_use_imm, in_reg_write, inputs, 1 each.
REQ-007 SHALL provide mem_fwd_valid, mem_fwd_rd[4:0], mem_fwd_data[XLEN], and wb_fwd_valid, wb_fwd_rd[4:0], wb_fwd_data[XLEN], inputs, downstream writeback results.
REQ-008 SHALL provide flush, input, 1, kill the held and incoming instruction.
REQ-009 SHALL provide out_valid/out_ready, output/input, 1 each, execute-side handshake.
REQ-010 SHALL provide src_a, src_b, outputs, XLEN, registered ALU operands; alu_instr, output, 4, registered ALU opcode.
REQ-011 SHALL provide out_rd_addr[5], out_reg_write[1], out_pc[XLEN], out_div_zero[1], outputs, registered sideband.

Function
REQ-012 SHALL hold one instruction; latency in_valid&&in_ready to out_valid is exactly 1 cycle.
REQ-013 SHALL drive in_ready = (!out_valid || out_ready) && !hazard, where hazard is defined in REQ-025.
REQ-014 SHALL capture all inputs on in_valid&&in_ready&&!flush; set out_valid=1.
REQ-015 SHALL clear out_valid when out_valid&&out_ready and no capture occurs that cycle.
REQ-016 SHALL keep all outputs stable while out_valid&&!out_ready.
REQ-017 SHALL resolve operand r = fwd(addr, regdata): addr==0 -> regdata; mem_fwd_valid&&mem_fwd_rd==addr -> mem_fwd_data; else wb_fwd_valid&&wb_fwd_rd==addr -> wb_fwd_data; else regdata (MEM priority over WB).
REQ-018 SHALL register src_a = in_use_pc ? in_pc : fwd(rs1); src_b = in_use_imm ? in_imm : fwd(rs2); forwarding evaluated in the capture cycle.
REQ-019 SHALL register out_div_zero = 1 when in_alu_op is 1110 or 1111 and resolved src_b==0, else 0.
REQ-020 SHALL force out_reg_write=0 whenever in_rd_addr==0.
REQ-021 SHALL, on flush, clear out_valid next edge, drop any same-cycle input beat, and drive in_ready=1 during flush; flush beats capture and hold.
REQ-022 SHALL, on simultaneous drain and capture (out_valid&&out_ready&&in_valid&&in_ready), load the new beat with out_valid staying 1.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force out_valid=0 and src_a, src_b, alu_instr, out_rd_addr, out_reg_write, out_pc, out_div_zero to 0.
REQ-024 SHALL discard a held beat on reset mid-operation; first capture allowed on first edge after rst_n rises.

Configuration
REQ-025 SHALL compile operand forwarding when FWD_BYPASS_EN is defined: REQ-017 active, hazard=0. Without it, fwd(addr, regdata)=regdata, and hazard=1 when a used nonzero rs address (rs1 if !in_use_pc, rs2 if !in_use_imm) equals mem_fwd_rd with mem_fwd_valid or wb_fwd_rd with wb_fwd_valid.

Verification
REQ-026 SHALL cover basic flow: in rs1_data=5, rs2_data=7, op=0000, out_ready=1 -> next cycle out_valid=1, src_a=5, src_b=7, alu_instr=0000.
REQ-027 SHALL cover forwarding priority (FWD_BYPASS_EN): rs1=3, mem_fwd rd=3 data=0xAA, wb_fwd rd=3 data=0xBB -> src_a=0xAA; same with rs1=0 -> src_a=in_rs1_data.
REQ-028 SHALL cover backpressure: out_ready=0 for 3 cycles with held beat -> in_ready=0, outputs unchanged; out_ready=1 with in_valid -> new beat loaded, out_valid stays 1.
REQ-029 SHALL cover flush: held beat plus flush=1 with in_valid=1 -> out_valid=0 next cycle, incoming beat absent.
REQ-030 SHALL cover div guard: op=1110, in_use_imm=1, in_imm=0 -> out_div_zero=1; op=0000 same operands -> out_div_zero=0.
REQ-031 SHALL cover reset mid-operation and hazard stall (macro undefined): rst_n=0 with out_valid=1 -> all outputs 0 immediately; rs2=4, wb_fwd rd=4 valid -> in_ready=0 until wb_fwd_valid=0.
